// File: rtl/sprite_cluster_pipe.sv
// Three-stage pipelined sprite compositor: bounds test, priority/texel address, texture read and colour key.
// One pixel per cycle, fixed 3-cycle latency, CPU-programmed sprite table plus texture RAM.
module sprite_cluster_pipe #(
    parameter int NUM_SPRITES    = 16,
    parameter int TEXTURE_WIDTH  = 64,
    parameter int TEXTURE_HEIGHT = 64,
    parameter int ADDR_WIDTH     = 16,
    parameter int INT_WIDTH      = 16,
    parameter int COLOR_WIDTH    = 12,
    parameter int SCALE_LOG2     = 1,
    parameter logic [COLOR_WIDTH-1:0] KEY_COLOR = 12'hF0F,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR  = 12'hFFF,
    localparam int ID_WIDTH = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [INT_WIDTH-1:0]   wdata,
    input  logic                   wen,
    input  logic                   in_valid,
    input  logic [INT_WIDTH-1:0]   x,
    input  logic [INT_WIDTH-1:0]   y,
    output logic                   out_valid,
    output logic [COLOR_WIDTH-1:0] pixel,
    output logic                   hit,
    output logic [ID_WIDTH-1:0]    hit_id
);
    localparam int TEX_DEPTH = TEXTURE_WIDTH * TEXTURE_HEIGHT;
    localparam int TEX_AW    = $clog2(TEX_DEPTH);
    localparam int SUM_W     = INT_WIDTH + SCALE_LOG2 + 1;
    localparam int REG_SPAN  = 8 * NUM_SPRITES;

    logic [NUM_SPRITES-1:0][INT_WIDTH-1:0] sx_q, sy_q, stx_q, sty_q, stw_q, sth_q;
    logic [NUM_SPRITES-1:0]                en_q, mir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q  <= '0;
            sy_q  <= '0;
            stx_q <= '0;
            sty_q <= '0;
            stw_q <= '0;
            sth_q <= '0;
            en_q  <= '0;
            mir_q <= '0;
        end else if (wen) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (waddr[ADDR_WIDTH-1:3] == (ADDR_WIDTH-3)'(k)) begin
                    case (waddr[2:0])
                        3'd0: sx_q[k]  <= wdata;
                        3'd1: sy_q[k]  <= wdata;
                        3'd2: stx_q[k] <= wdata;
                        3'd3: sty_q[k] <= wdata;
                        3'd4: stw_q[k] <= wdata;
                        3'd5: sth_q[k] <= wdata;
                        3'd6: begin
                            en_q[k]  <= wdata[0];
                            mir_q[k] <= wdata[1];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Texture window starts right after the sprite table; out-of-range texels are dropped.
    logic [ADDR_WIDTH-1:0] tex_idx;
    logic                  tex_we;
    assign tex_idx = waddr - ADDR_WIDTH'(REG_SPAN);
    assign tex_we  = wen && ({1'b0, waddr} >= (ADDR_WIDTH+1)'(REG_SPAN))
                         && (32'(tex_idx) < 32'(TEX_DEPTH));

    // Stage 1: per-sprite bounds test with widened sums so the right/bottom edge never wraps.
    logic [SUM_W-1:0]                      x_ext, y_ext;
    logic [NUM_SPRITES-1:0]                hit_d, s1_hit_q;
    logic [NUM_SPRITES-1:0][INT_WIDTH-1:0] dx_d, dy_d, s1_dx_q, s1_dy_q;
    logic                                  s1_valid_q;

    assign x_ext = SUM_W'(x);
    assign y_ext = SUM_W'(y);

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_s1
        logic [SUM_W-1:0] x_lo, x_hi, y_lo, y_hi;
        assign x_lo = SUM_W'(sx_q[gi]);
        assign y_lo = SUM_W'(sy_q[gi]);
        assign x_hi = x_lo + (SUM_W'(stw_q[gi]) << SCALE_LOG2);
        assign y_hi = y_lo + (SUM_W'(sth_q[gi]) << SCALE_LOG2);
        assign hit_d[gi] = en_q[gi] && (x_ext >= x_lo) && (x_ext < x_hi)
                                    && (y_ext >= y_lo) && (y_ext < y_hi);
        assign dx_d[gi] = (x - sx_q[gi]) >> SCALE_LOG2;
        assign dy_d[gi] = (y - sy_q[gi]) >> SCALE_LOG2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_hit_q   <= hit_d;
            s1_dx_q    <= dx_d;
            s1_dy_q    <= dy_d;
        end
    end

    // Stage 2: lowest index wins, so scan downwards and let the last match stick.
    logic                 any_d;
    logic [ID_WIDTH-1:0]  id_d;
    logic [INT_WIDTH-1:0] u_d, v_d;
    logic [TEX_AW-1:0]    raddr_d;

    always_comb begin
        any_d = 1'b0;
        id_d  = '0;
        u_d   = '0;
        v_d   = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (s1_hit_q[k]) begin
                any_d = 1'b1;
                id_d  = ID_WIDTH'(k);
                u_d   = mir_q[k] ? (stx_q[k] + stw_q[k] - INT_WIDTH'(1) - s1_dx_q[k])
                                 : (stx_q[k] + s1_dx_q[k]);
                v_d   = sty_q[k] + s1_dy_q[k];
            end
        end
    end

    assign raddr_d = TEX_AW'(v_d * TEXTURE_WIDTH) + TEX_AW'(u_d);

    logic [COLOR_WIDTH-1:0] tex_mem [TEX_DEPTH];
    logic [COLOR_WIDTH-1:0] tex_rdata_q;

    // Read-first: a same-cycle write to the texel being read returns the old data.
    always_ff @(posedge clk) begin
        if (tex_we) begin
            tex_mem[tex_idx[TEX_AW-1:0]] <= wdata[COLOR_WIDTH-1:0];
        end
        tex_rdata_q <= tex_mem[raddr_d];
    end

    logic                s2_valid_q, s2_any_q;
    logic [ID_WIDTH-1:0] s2_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_any_q   <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_any_q   <= any_d;
            s2_id_q    <= id_d;
        end
    end

    // Stage 3: colour key on the winning sprite only; a keyed texel falls through to background.
    logic                   opaque_d;
    logic                   out_valid_q, hit_q;
    logic [COLOR_WIDTH-1:0] pixel_q;
    logic [ID_WIDTH-1:0]    hit_id_q;

    assign opaque_d = s2_any_q && (tex_rdata_q != KEY_COLOR);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pixel_q     <= BG_COLOR;
            hit_q       <= 1'b0;
            hit_id_q    <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            pixel_q     <= opaque_d ? tex_rdata_q : BG_COLOR;
            hit_q       <= opaque_d;
            hit_id_q    <= opaque_d ? s2_id_q : '0;
        end
    end

    assign out_valid = out_valid_q;
    assign pixel     = pixel_q;
    assign hit       = hit_q;
    assign hit_id    = hit_id_q;
endmodule
